// File: rtl/div_seq_pkg.sv
// Shared definitions for the sequential restoring divider.
package div_seq_pkg;

    // Divider control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Default operand/result width
    localparam int DEF_WIDTH = 4;

    // Iteration counter width for the default width
    localparam int DEF_CNT_W = $clog2(DEF_WIDTH + 1);

    // Counter width needed to hold the value w (number of iterations)
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/div_seq_addsub_w.sv
// Parameterized ripple-carry adder/subtractor: sum = a + (b ^ sel) + sel.
module addsub_w #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] sum
);

    logic [WIDTH-1:0] b_x;
    logic [WIDTH-1:0] carry;

    // In subtract mode b is inverted and the carry-in supplies the +1
    assign b_x      = b ^ {WIDTH{sel}};
    assign carry[0] = sel;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign sum[gi] = a[gi] ^ b_x[gi] ^ carry[gi];
            // The carry out of the top bit is not needed by any user
            if (gi < WIDTH - 1) begin : g_carry
                assign carry[gi+1] = (a[gi] & b_x[gi]) | (carry[gi] & (a[gi] ^ b_x[gi]));
            end
        end
    endgenerate

endmodule

// File: rtl/div_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);

    state_t state, state_next;

    // The partial remainder is always below the divisor after a step, so its
    // top (WIDTH+1)th bit is always zero and only WIDTH bits are stored.
    logic [WIDTH-1:0] p_reg;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] d_reg;
    logic [CW-1:0]    cnt_reg;

    logic [WIDTH:0]   p_sh;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] quo_sh;
    logic [WIDTH-1:0] p_iter;
    logic [WIDTH-1:0] quo_iter;
    logic             accept;
    logic             last_iter;

    assign accept    = (state == IDLE) && start;
    assign last_iter = (state == RUN) && (cnt_reg == CW'(1));

    // Shift {P,Q} left by one
    assign p_sh   = {p_reg, quo_reg[WIDTH-1]};
    assign quo_sh = {quo_reg[WIDTH-2:0], 1'b0};

    // Trial subtraction P_shifted - {0,D}
    addsub_w #(
        .WIDTH(WIDTH + 1)
    ) u_trial (
        .a   (p_sh),
        .b   ({1'b0, d_reg}),
        .sel (1'b1),
        .sum (trial)
    );

    // Restore decision: keep the difference only when it did not borrow
    always_comb begin
        p_iter   = p_sh[WIDTH-1:0];
        quo_iter = quo_sh;
        if (!trial[WIDTH]) begin
            p_iter   = trial[WIDTH-1:0];
            quo_iter = quo_sh | WIDTH'(1);
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (b == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (cnt_reg == CW'(1)) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs decoded from the state
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Operand capture, iteration datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_reg       <= '0;
            quo_reg     <= '0;
            d_reg       <= '0;
            cnt_reg     <= '0;
            q           <= '0;
            r           <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            p_reg       <= '0;
            quo_reg     <= a;
            d_reg       <= b;
            cnt_reg     <= CW'(WIDTH);
            div_by_zero <= (b == '0);
            // A zero divisor finishes immediately with the fixed result
            if (b == '0) begin
                q <= '1;
                r <= a;
            end
        end else if (state == RUN) begin
            p_reg   <= p_iter;
            quo_reg <= quo_iter;
            cnt_reg <= cnt_reg - CW'(1);
            if (last_iter) begin
                q <= quo_iter;
                r <= p_iter;
            end
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Directed and sweep test of the sequential restoring divider.
module tb_div_seq;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_seq #(
        .WIDTH(W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .q           (q),
        .r           (r),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One request from IDLE; optionally pokes a second start during RUN
    task automatic run_op(input string nm, input logic [W-1:0] va, input logic [W-1:0] vb,
                          input int exp_q, input int exp_r, input int exp_dz,
                          input int exp_lat, input int exp_busy, input bit inject);
        int lat;
        int busy_cnt;
        @(negedge clk);
        a     = va;
        b     = vb;
        start = 1'b1;
        @(posedge clk);
        busy_cnt = 0;
        for (lat = 0; lat < 40; lat++) begin
            @(negedge clk);
            check({nm, "_excl"}, 32'(done & busy), 0);
            if (done) break;
            if (busy) busy_cnt++;
            start = inject && (lat == 1);
            if (inject && lat == 1) begin
                a = 4'd14;
                b = 4'd3;
            end
        end
        start = 1'b0;
        check({nm, "_done"}, 32'(done), 1);
        check({nm, "_lat"}, 32'(lat), 32'(exp_lat));
        check({nm, "_busy"}, 32'(busy_cnt), 32'(exp_busy));
        check({nm, "_q"}, 32'(q), 32'(exp_q));
        check({nm, "_r"}, 32'(r), 32'(exp_r));
        check({nm, "_dz"}, 32'(div_by_zero), 32'(exp_dz));
        @(negedge clk);
        check({nm, "_done_fall"}, 32'(done), 0);
        check({nm, "_busy_after"}, 32'(busy), 0);
        check({nm, "_q_hold"}, 32'(q), 32'(exp_q));
        check({nm, "_r_hold"}, 32'(r), 32'(exp_r));
        $display("op %s a=%0d b=%0d -> q=%0d r=%0d dz=%0d lat=%0d", nm, va, vb, q, r, div_by_zero, lat);
    endtask

    initial begin
        int n;
        int gap;
        logic [W-1:0] ea, eb, eq, er;
        logic dz;

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_q", 32'(q), 0);
        check("rst_r", 32'(r), 0);
        check("rst_dz", 32'(div_by_zero), 0);
        rst_n = 1'b1;

        run_op("d13_4", 4'd13, 4'd4, 3, 1, 0, 4, 4, 1'b0);
        run_op("d15_1", 4'd15, 4'd1, 15, 0, 0, 4, 4, 1'b0);
        run_op("d3_5", 4'd3, 4'd5, 0, 3, 0, 4, 4, 1'b0);
        run_op("d7_0", 4'd7, 4'd0, 15, 7, 1, 0, 0, 1'b0);
        run_op("d9_2_inj", 4'd9, 4'd2, 4, 1, 0, 4, 4, 1'b1);

        // Abort mid-RUN with an asynchronous reset
        @(negedge clk);
        a     = 4'd12;
        b     = 4'd5;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_q", 32'(q), 0);
        check("abort_r", 32'(r), 0);
        check("abort_dz", 32'(div_by_zero), 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("abort_no_done", 32'(done), 0);
        end
        rst_n = 1'b1;
        $display("op abort a=12 b=5 -> q=%0d r=%0d busy=%0d done=%0d", q, r, busy, done);
        run_op("d12_5", 4'd12, 4'd5, 2, 2, 0, 4, 4, 1'b0);

        // Exhaustive sweep with start held high
        @(negedge clk);
        a     = '0;
        b     = '0;
        start = 1'b1;
        for (int i = 0; i < 256; i++) begin
            ea = 4'(i >> 4);
            eb = 4'(i);
            n  = 0;
            while (!done && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (eb == '0) begin
                eq = 4'hF;
                er = ea;
                dz = 1'b1;
            end else begin
                eq = ea / eb;
                er = ea % eb;
                dz = 1'b0;
            end
            check("sweep_done", 32'(done), 1);
            check("sweep_q", 32'(q), 32'(eq));
            check("sweep_r", 32'(r), 32'(er));
            check("sweep_dz", 32'(div_by_zero), 32'(dz));
            if (eb != '0) begin
                check("sweep_inv", 32'(q) * 32'(eb) + 32'(r), 32'(ea));
            end
            $display("sweep a=%0d b=%0d -> q=%0d r=%0d dz=%0d", ea, eb, q, r, div_by_zero);
            if (i < 255) begin
                a   = 4'((i + 1) >> 4);
                b   = 4'(i + 1);
                gap = 0;
                @(negedge clk);
                while (!busy && !done && gap < 10) begin
                    gap++;
                    @(negedge clk);
                end
                check("sweep_gap", 32'(gap), 1);
            end else begin
                start = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
